// File: rtl/logger_pkg.sv
// Shared definitions for the event-logger byte stream: sync marker, FSM states
// and the CRC-8 (poly 0x07) byte update.
package logger_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } logger_state_e;

  // One byte of CRC-8, MSB first, no reflection, no final xor.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/logger_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starting just
// after the last accepted channel; the pointer only moves on accept.
module logger_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant_c,
  output logic [IDX_W-1:0]  grant_idx_c
);

  generate
    if (NUM_CH == 1) begin : g_single
      logic unused_arb;
      assign unused_arb  = ^{clk, rst_n, accept};
      assign grant_c     = req;
      assign grant_idx_c = '0;
    end else begin : g_rr
      localparam int unsigned SUM_W = IDX_W + 1;
      logic [IDX_W-1:0] last_q;

      // Reset to the top channel so channel 0 is searched first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_q <= IDX_W'(NUM_CH - 1);
        end else if (accept) begin
          last_q <= grant_idx_c;
        end
      end

      // Walk from farthest to nearest so the nearest requester wins.
      always_comb begin
        logic [SUM_W-1:0] sum;
        grant_c     = '0;
        grant_idx_c = last_q;
        sum         = '0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
          sum = {1'b0, last_q} + SUM_W'(k);
          if (sum >= SUM_W'(NUM_CH)) begin
            sum = sum - SUM_W'(NUM_CH);
          end
          if (req[sum[IDX_W-1:0]]) begin
            grant_c                 = '0;
            grant_c[sum[IDX_W-1:0]] = 1'b1;
            grant_idx_c             = sum[IDX_W-1:0];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_logger_mux.sv
// Multiplexes NUM_CH timestamped event channels into a framed byte stream.
// Define LOGGER_CRC8_EN to append a CRC-8 byte to every record.
module uart_logger_mux
  import logger_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned TS_W   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      ev_valid,
  output logic [NUM_CH-1:0]      ev_ready,
  input  logic [NUM_CH*ID_W-1:0] ev_id,
  input  logic [NUM_CH*TS_W-1:0] ev_start,
  input  logic [NUM_CH*TS_W-1:0] ev_end,
  input  logic [NUM_CH*TS_W-1:0] ev_delta,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [7:0]             byte_data,
  output logic                   byte_last
);

  localparam int unsigned IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DATA_BYTES = 2 + ID_W / 8 + 3 * (TS_W / 8);
`ifdef LOGGER_CRC8_EN
  localparam int unsigned REC_LEN    = DATA_BYTES + 1;
`else
  localparam int unsigned REC_LEN    = DATA_BYTES;
`endif
  localparam int unsigned CNT_W      = $clog2(REC_LEN);
  localparam int unsigned SHIFT_W    = DATA_BYTES * 8;

  logger_state_e     state_q;
  logger_state_e     state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] record_c;
  logic              accept_en_q;
  logic [NUM_CH-1:0] grant_c;
  logic [IDX_W-1:0]  grant_idx_c;
  logic              capture_c;
  logic              advance_c;
`ifdef LOGGER_CRC8_EN
  logic [7:0]        crc_q;
`endif

  logger_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (ev_valid),
    .accept      (capture_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign capture_c = |(ev_valid & ev_ready);
  assign advance_c = byte_valid & byte_ready;

  // Frame: sync, channel, ID, start, end, delta -- all MSB byte first.
  assign record_c = {SYNC_BYTE,
                     8'(grant_idx_c),
                     ev_id[grant_idx_c*ID_W +: ID_W],
                     ev_start[grant_idx_c*TS_W +: TS_W],
                     ev_end[grant_idx_c*TS_W +: TS_W],
                     ev_delta[grant_idx_c*TS_W +: TS_W]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_c) state_d = SEND;
      SEND:    if (advance_c && byte_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ready stays low until the first clock after reset release.
  always_comb begin
    ev_ready   = '0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    case (state_q)
      IDLE:    ev_ready = accept_en_q ? grant_c : '0;
      SEND: begin
        byte_valid = 1'b1;
        byte_last  = (cnt_q == CNT_W'(REC_LEN - 1));
      end
      default: ;
    endcase
  end

`ifdef LOGGER_CRC8_EN
  assign byte_data = byte_last ? crc_q : shift_q[SHIFT_W-1 -: 8];
`else
  assign byte_data = shift_q[SHIFT_W-1 -: 8];
`endif

  // Record shift register and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_en_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      accept_en_q <= 1'b1;
      if (capture_c) begin
        cnt_q   <= '0;
        shift_q <= record_c;
      end else if (advance_c) begin
        cnt_q   <= byte_last ? '0 : cnt_q + CNT_W'(1);
        shift_q <= shift_q << 8;
      end
    end
  end

`ifdef LOGGER_CRC8_EN
  // Running CRC over every byte already accepted in this record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (capture_c) begin
      crc_q <= '0;
    end else if (advance_c) begin
      crc_q <= crc8_update(crc_q, byte_data);
    end
  end
`endif

endmodule
